fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the RISC-V datapath. It replaces the bare PC register, PC+4 adder, branch-target adder and branch mux with one block.
- Holds the PC and issues requests to a 1-cycle-latency instruction memory. Buffers returned instructions with their PCs in a DEPTH-entry queue, which hands them to decode over a valid/ready handshake.
- Resolved taken branches redirect the PC to br_pc + br_imm and flush all younger fetched work.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_if.sv | 42 ++++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction-fetch stage.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fetch_pkg;

  localparam int unsigned FETCH_XLEN    = 32;
  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned FETCH_PC_INC  = 4;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_XLEN-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_if : imem request/response, decode handshake and redirect bundle.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fetch_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned INSTR_W = 32
);

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [XLEN-1:0]    dec_pc;
  logic               br_taken;
  logic [XLEN-1:0]    br_pc;
  logic [XLEN-1:0]    br_imm;
  logic               br_misalign;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    output dec_valid, dec_instr, dec_pc,
    input  dec_ready,
    input  br_taken, br_pc, br_imm,
    output br_misalign
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    input  dec_valid, dec_instr, dec_pc,
    output dec_ready,
    output br_taken, br_pc, br_imm,
    input  br_misalign
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_queue : DEPTH-entry circular buffer with push, pop and flush.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         ENTRY_T = fetch_entry_t
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       flush_i,
  input  wire logic                       push_i,
  input  wire ENTRY_T                     wdata_i,
  input  wire logic                       pop_i,
  output      ENTRY_T                     rdata_o,
  output      logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  ENTRY_T          mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Flush realigns the read side onto the write side so no stale slot is reused.
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : PC, imem requests, fetch queue and branch redirect.         |
// | Optional FETCH_MISALIGN_CHECK_EN flags and word-aligns odd targets.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC),
  parameter int unsigned     INSTR_W  = 32
) (
  input  wire logic clk,
  input  wire logic reset,
  fetch_if.master   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;
  logic            inflight_q, inflight_d;
  logic            kill_q, kill_d;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_misalign;
  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit;
  logic            w_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_req;
  entry_t          w_head;
  entry_t          w_wentry;

  assign w_target = bus.br_pc + bus.br_imm;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign w_misalign    = bus.br_taken & (w_target[1:0] != 2'b00);
  assign w_redirect_pc = {w_target[XLEN-1:2], 2'b00};
`else
  assign w_misalign    = 1'b0;
  assign w_redirect_pc = w_target;
`endif

  assign w_valid  = (w_count != '0) & ~bus.br_taken & ~reset;
  assign w_pop    = w_valid & bus.dec_ready;
  // Credit counts queued plus in-flight slots so a response always has room.
  assign w_credit = {1'b0, w_count} + (CW+1)'(inflight_q) - (CW+1)'(w_pop);
  assign w_req    = ~reset & ~bus.br_taken & (w_credit < (CW+1)'(DEPTH));
  assign w_push   = inflight_q & ~kill_q & ~bus.br_taken & ~reset;

  assign w_wentry = '{pc: req_pc_q, instr: bus.imem_rdata};

  always_comb begin
    pc_d       = pc_q;
    inflight_d = w_req;
    kill_d     = 1'b0;
    if (bus.br_taken) begin
      pc_d   = w_redirect_pc;
      kill_d = inflight_q;
    end else if (w_req) begin
      pc_d = pc_q + XLEN'(FETCH_PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= pc_q;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.br_taken),
    .push_i  (w_push),
    .wdata_i (w_wentry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = pc_q;
  assign bus.dec_valid   = w_valid;
  assign bus.dec_instr   = w_head.instr;
  assign bus.dec_pc      = w_head.pc;
  assign bus.br_misalign = w_misalign & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed cycle vectors plus reset and misalign sequences.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.XLEN(32), .INSTR_W(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .INSTR_W  (32)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory model: word at address a holds a + 0x100.
  always @(posedge clk) begin
    if (bus.imem_req === 1'b1) bus.imem_rdata <= bus.imem_addr + 32'h100;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (u_dut.w_push === 1'b1 && u_dut.u_queue.count_o == 3'd4) begin
        failures++;
        $display("FAIL push_when_full: count %0d push %b", u_dut.u_queue.count_o, u_dut.w_push);
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] bimm;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rdy, input logic br,
                     input logic [31:0] bpc, input logic [31:0] bimm,
                     input logic ereq, input logic [31:0] eaddr,
                     input logic evalid, input logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.br = br; v.bpc = bpc; v.bimm = bimm;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic br,
                       input logic [31:0] bpc, input logic [31:0] bimm);
    reset         = rst;
    bus.dec_ready = rdy;
    bus.br_taken  = br;
    bus.br_pc     = bpc;
    bus.br_imm    = bimm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic        MIS_EN  = 1'b1;
`else
  localparam logic        MIS_EN  = 1'b0;
`endif
  localparam logic [31:0] MIS_TGT = MIS_EN ? 32'h14 : 32'h16;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // rst rdy br  bpc           bimm      | req addr      valid pc
    add(1, 0, 0, 32'h0,        32'h0,      0, 32'h00,   0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,      1, 32'h00,   0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,      1, 32'h04,   0, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,      1, 32'h08,   1, 32'h0);
    add(0, 0, 0, 32'h0,        32'h0,      1, 32'h0C,   1, 32'h0);
    for (int i = 0; i < 6; i++)
      add(0, 0, 0, 32'h0,      32'h0,      0, 32'h10,   1, 32'h0);
    for (int i = 0; i < 7; i++)
      add(0, 1, 0, 32'h0,      32'h0,      1, 32'h10 + 32'(4*i), 1, 32'(4*i));
    add(0, 1, 1, 32'h20,       32'h40,     0, 32'h2C,   0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h60,   0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h64,   0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h68,   1, 32'h60);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h6C,   1, 32'h64);
    add(0, 1, 1, 32'h80,       32'h80,     0, 32'h70,   0, 32'h0);
    add(0, 1, 1, 32'h180,      32'h80,     0, 32'h100,  0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h200,  0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h204,  0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h208,  1, 32'h200);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h20C,  1, 32'h204);
    add(0, 1, 1, 32'hFFFF_FFF0, 32'h20,    0, 32'h210,  0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h10,   0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h14,   0, 32'h0);
    add(0, 1, 0, 32'h0,        32'h0,      1, 32'h18,   1, 32'h10);

    step();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].br, tbl[i].bpc, tbl[i].bimm);
      @(negedge clk);
      chk($sformatf("row%0d imem_req", i), 32'(bus.imem_req), 32'(tbl[i].ereq));
      chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].eaddr);
      chk($sformatf("row%0d dec_valid", i), 32'(bus.dec_valid), 32'(tbl[i].evalid));
      chk($sformatf("row%0d br_misalign", i), 32'(bus.br_misalign), 32'h0);
      if (tbl[i].evalid) begin
        chk($sformatf("row%0d dec_pc", i), bus.dec_pc, tbl[i].epc);
        chk($sformatf("row%0d dec_instr", i), bus.dec_instr, tbl[i].epc + 32'h100);
      end
      step();
    end

    // Fill the queue, then reset with it full.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step();
    end
    @(negedge clk);
    chk("full count", 32'(u_dut.u_queue.count_o), 32'd4);
    chk("full imem_req", 32'(bus.imem_req), 32'd0);
    chk("full dec_pc", bus.dec_pc, 32'h14);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("in_reset imem_req", 32'(bus.imem_req), 32'd0);
    chk("in_reset dec_valid", 32'(bus.dec_valid), 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_reset count", 32'(u_dut.u_queue.count_o), 32'd0);
    chk("post_reset dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("post_reset imem_addr", bus.imem_addr, 32'h0);
    step();
    @(negedge clk);
    chk("post_reset+1 dec_valid", 32'(bus.dec_valid), 32'd0);
    step();
    @(negedge clk);
    chk("post_reset+2 dec_valid", 32'(bus.dec_valid), 32'd1);
    chk("post_reset+2 dec_pc", bus.dec_pc, 32'h0);
    chk("post_reset+2 dec_instr", bus.dec_instr, 32'h100);
    step();

    // Redirect to an unaligned target.
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h6);
    @(negedge clk);
    chk("mis br_misalign", 32'(bus.br_misalign), 32'(MIS_EN));
    chk("mis dec_valid", 32'(bus.dec_valid), 32'd0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("mis imem_addr", bus.imem_addr, MIS_TGT);
    chk("mis br_misalign_clear", 32'(bus.br_misalign), 32'd0);
    step();
    step();
    @(negedge clk);
    chk("mis dec_valid_after", 32'(bus.dec_valid), 32'd1);
    chk("mis dec_pc", bus.dec_pc, MIS_TGT);
    chk("mis dec_instr", bus.dec_instr, MIS_TGT + 32'h100);
    step();

    reset = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
